// File: rtl/keypad_encoder.sv
// keypad_encoder: turns 16-key press/release requests into PS/2-style scan-code byte sequences.
//
// Ports:
//   clk          rising-edge clock
//   reset        asynchronous, active-high; clears all state
//   key[3:0]     keypad index, sampled when a request is accepted
//   press        one-cycle request for the make sequence of key
//   key_release  one-cycle request for the break sequence of key ("release" is an SV keyword)
//   byte_out     current scan-code byte (0 when no byte is offered)
//   byte_valid   byte_out valid; held until transferred (byte_valid & byte_ready on a rising edge)
//   byte_ready   consumer accepts the offered byte
//   keyCode      {extended, code} of the last completed sequence
//   make         one-cycle pulse when a make sequence completes
//   brakee       one-cycle pulse when a break sequence completes
//   busy         high whenever the FSM is not idle
//   req_drop     one-cycle pulse, the cycle after a request was discarded because busy was high
//
// GAP_CYCLES idle cycles (byte_valid low) follow each byte except the last of a sequence.
module keypad_encoder #(
  parameter int unsigned GAP_CYCLES = 0
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] key,
  input  logic       press,
  input  logic       key_release,
  output logic [7:0] byte_out,
  output logic       byte_valid,
  input  logic       byte_ready,
  output logic [8:0] keyCode,
  output logic       make,
  output logic       brakee,
  output logic       busy,
  output logic       req_drop
);

  localparam int unsigned GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES + 1) : 1;

  localparam logic [2:0] IDLE      = 3'd0;
  localparam logic [2:0] SEND_E0   = 3'd1;
  localparam logic [2:0] SEND_F0   = 3'd2;
  localparam logic [2:0] SEND_CODE = 3'd3;
  localparam logic [2:0] GAP       = 3'd4;
  localparam logic [2:0] DONE      = 3'd5;

  localparam logic [3:0] EXT_KEY = 4'd11;

  logic [2:0]    state;
  logic [2:0]    ret_state;   // byte state to resume after a gap
  logic [2:0]    after_state; // state following a transfer in the current byte state
  logic [3:0]    key_q;
  logic          brk_q;
  logic [15:0]   held;
  logic [GW-1:0] gap_cnt;

  function automatic logic [7:0] scan_code(input logic [3:0] k);
    case (k)
      4'd0:    scan_code = 8'h70;
      4'd1:    scan_code = 8'h69;
      4'd2:    scan_code = 8'h72;
      4'd3:    scan_code = 8'h7A;
      4'd4:    scan_code = 8'h6B;
      4'd5:    scan_code = 8'h73;
      4'd6:    scan_code = 8'h74;
      4'd7:    scan_code = 8'h6C;
      4'd8:    scan_code = 8'h75;
      4'd9:    scan_code = 8'h7D;
      4'd10:   scan_code = 8'h77;
      4'd11:   scan_code = 8'h4A;
      4'd12:   scan_code = 8'h7C;
      4'd13:   scan_code = 8'h7B;
      4'd14:   scan_code = 8'h79;
      default: scan_code = 8'h71;
    endcase
  endfunction

  // Outputs decode directly from state so byte_out cannot change while a byte is stalled.
  always_comb begin
    byte_valid = 1'b0;
    byte_out   = 8'h00;
    case (state)
      SEND_E0:   begin byte_valid = 1'b1; byte_out = 8'hE0;            end
      SEND_F0:   begin byte_valid = 1'b1; byte_out = 8'hF0;            end
      SEND_CODE: begin byte_valid = 1'b1; byte_out = scan_code(key_q); end
      default:   ;
    endcase
    busy   = (state != IDLE);
    make   = (state == DONE) && !brk_q;
    brakee = (state == DONE) && brk_q;
  end

  always_comb begin
    after_state = DONE;
    case (state)
      SEND_E0: after_state = brk_q ? SEND_F0 : SEND_CODE;
      SEND_F0: after_state = SEND_CODE;
      default: after_state = DONE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      ret_state <= IDLE;
      key_q     <= 4'd0;
      brk_q     <= 1'b0;
      held      <= 16'd0;
      gap_cnt   <= '0;
      keyCode   <= 9'd0;
      req_drop  <= 1'b0;
    end else begin
      // Simultaneous press+release while idle is not a drop: press simply wins.
      req_drop <= busy && (press || key_release);
      case (state)
        IDLE: begin
          if (press) begin
            key_q <= key;
            brk_q <= 1'b0;
            state <= (key == EXT_KEY) ? SEND_E0 : SEND_CODE;
          end else if (key_release && held[key]) begin
            key_q <= key;
            brk_q <= 1'b1;
            state <= (key == EXT_KEY) ? SEND_E0 : SEND_F0;
          end
        end
        SEND_E0, SEND_F0, SEND_CODE: begin
          if (byte_ready) begin
            if (after_state == DONE) begin
              state       <= DONE;
              keyCode     <= {key_q == EXT_KEY, scan_code(key_q)};
              held[key_q] <= !brk_q;
            end else if (GAP_CYCLES > 0) begin
              state     <= GAP;
              ret_state <= after_state;
              gap_cnt   <= GW'(GAP_CYCLES - 1);
            end else begin
              state <= after_state;
            end
          end
        end
        GAP: begin
          if (gap_cnt == '0) state <= ret_state;
          else gap_cnt <= gap_cnt - GW'(1);
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_keypad_encoder.sv
module tb_keypad_encoder;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset;
  logic [3:0] key, g_key;
  logic       press, rel, ready, g_press, g_rel, g_ready;
  logic [7:0] byte_out, g_byte_out;
  logic       byte_valid, make, brakee, busy, req_drop;
  logic       g_byte_valid, g_make, g_brakee, g_busy, g_req_drop;
  logic [8:0] key_code, g_key_code;

  keypad_encoder #(.GAP_CYCLES(0)) dut (
    .clk(clk), .reset(reset), .key(key), .press(press), .key_release(rel),
    .byte_out(byte_out), .byte_valid(byte_valid), .byte_ready(ready), .keyCode(key_code),
    .make(make), .brakee(brakee), .busy(busy), .req_drop(req_drop)
  );

  keypad_encoder #(.GAP_CYCLES(2)) gdut (
    .clk(clk), .reset(reset), .key(g_key), .press(g_press), .key_release(g_rel),
    .byte_out(g_byte_out), .byte_valid(g_byte_valid), .byte_ready(g_ready),
    .keyCode(g_key_code), .make(g_make), .brakee(g_brakee), .busy(g_busy),
    .req_drop(g_req_drop)
  );

  // Token = {kind, data}
  localparam logic [2:0] KB = 3'd1;  // byte transferred
  localparam logic [2:0] KM = 3'd2;  // make pulse with keyCode
  localparam logic [2:0] KK = 3'd3;  // brakee pulse with keyCode
  localparam logic [2:0] KD = 3'd4;  // req_drop pulse
  localparam logic [2:0] KG = 3'd5;  // busy cycle with nothing offered (gap)

  logic [11:0] q_main[$];
  logic [11:0] q_gap[$];
  int checks = 0;
  int errors = 0;
  logic       stall[2];
  logic [7:0] sbyte[2];

  function automatic logic [11:0] tk(input logic [2:0] k, input logic [8:0] d);
    return {k, d};
  endfunction

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h required %0h", name, got, exp);
    end
  endtask

  task automatic pop_cmp(input int w, input logic [11:0] got);
    logic [11:0] exp;
    if ((w == 0 && q_main.size() == 0) || (w == 1 && q_gap.size() == 0)) begin
      checks++;
      errors++;
      $display("FAIL unexpected_event dut%0d: got %h required none", w, got);
    end else begin
      exp = (w == 0) ? q_main.pop_front() : q_gap.pop_front();
      check($sformatf("event dut%0d", w), {20'd0, got}, {20'd0, exp});
    end
  endtask

  task automatic mon(input int w, input logic v, input logic r, input logic [7:0] b,
                     input logic mk, input logic bk, input logic dr, input logic bs,
                     input logic [8:0] kc);
    if (stall[w]) check($sformatf("stall_stable dut%0d", w), {23'd0, v, b}, {23'd0, 1'b1, sbyte[w]});
    if (mk || bk) check($sformatf("make_brakee_excl dut%0d", w), {31'd0, mk && bk}, 32'd0);
    if (v && r) pop_cmp(w, tk(KB, {1'b0, b}));
    if (mk) pop_cmp(w, tk(KM, kc));
    if (bk) pop_cmp(w, tk(KK, kc));
    if (dr) pop_cmp(w, tk(KD, 9'd0));
    if (bs && !v && !mk && !bk) pop_cmp(w, tk(KG, 9'd0));
    stall[w] = v && !r;
    sbyte[w] = b;
  endtask

  always @(negedge clk) begin
    if (reset) begin
      stall[0] = 1'b0;
      stall[1] = 1'b0;
    end else begin
      mon(0, byte_valid, ready, byte_out, make, brakee, req_drop, busy, key_code);
      mon(1, g_byte_valid, g_ready, g_byte_out, g_make, g_brakee, g_req_drop, g_busy, g_key_code);
    end
  end

  // Request is presented across exactly one rising edge; returns 1 time unit after that edge.
  task automatic req(input logic p, input logic r, input logic [3:0] k);
    @(posedge clk);
    #1 press = p; rel = r; key = k;
    @(posedge clk);
    #1 press = 1'b0; rel = 1'b0;
  endtask

  task automatic g_req(input logic p, input logic r, input logic [3:0] k);
    @(posedge clk);
    #1 g_press = p; g_rel = r; g_key = k;
    @(posedge clk);
    #1 g_press = 1'b0; g_rel = 1'b0;
  endtask

  task automatic wait_idle(input int w);
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (!(w == 1 ? g_busy : busy)) return;
    end
    checks++;
    errors++;
    $display("FAIL idle_timeout dut%0d: got busy required idle", w);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_byte_valid"}, {31'd0, byte_valid}, 32'd0);
    check({tag, "_byte_out"},   {24'd0, byte_out},   32'd0);
    check({tag, "_keyCode"},    {23'd0, key_code},   32'd0);
    check({tag, "_make"},       {31'd0, make},       32'd0);
    check({tag, "_brakee"},     {31'd0, brakee},     32'd0);
    check({tag, "_busy"},       {31'd0, busy},       32'd0);
    check({tag, "_req_drop"},   {31'd0, req_drop},   32'd0);
    check({tag, "_held"},       {16'd0, dut.held},   32'd0);
  endtask

  initial begin
    reset = 1'b1;
    press = 1'b0; rel = 1'b0; key = 4'd0; ready = 1'b1;
    g_press = 1'b0; g_rel = 1'b0; g_key = 4'd0; g_ready = 1'b1;
    stall[0] = 1'b0; stall[1] = 1'b0;
    sbyte[0] = 8'd0; sbyte[1] = 8'd0;
    repeat (2) @(negedge clk);
    check_reset_outputs("reset");
    check("reset_g_busy", {31'd0, g_busy}, 32'd0);
    @(posedge clk);
    #1 reset = 1'b0;

    // Normal make, exact cycle timing
    q_main.push_back(tk(KB, 9'h073));
    q_main.push_back(tk(KM, 9'h073));
    req(1'b1, 1'b0, 4'd5);
    @(negedge clk);
    check("t1_valid_byte", {23'd0, byte_valid, byte_out}, {23'd0, 1'b1, 8'h73});
    @(negedge clk);
    check("t2_make_code", {22'd0, make, key_code}, {22'd0, 1'b1, 9'h073});
    @(negedge clk);
    check("t3_busy", {31'd0, busy}, 32'd0);
    check("held5_set", {31'd0, dut.held[5]}, 32'd1);

    // Extended key make then break
    q_main.push_back(tk(KB, 9'h0E0));
    q_main.push_back(tk(KB, 9'h04A));
    q_main.push_back(tk(KM, 9'h14A));
    req(1'b1, 1'b0, 4'd11);
    wait_idle(0);
    q_main.push_back(tk(KB, 9'h0E0));
    q_main.push_back(tk(KB, 9'h0F0));
    q_main.push_back(tk(KB, 9'h04A));
    q_main.push_back(tk(KK, 9'h14A));
    req(1'b0, 1'b1, 4'd11);
    wait_idle(0);
    check("held11_clr", {31'd0, dut.held[11]}, 32'd0);
    check("keyCode_hold", {23'd0, key_code}, 32'h14A);

    // Backpressure: byte held for 3 stalled cycles
    ready = 1'b0;
    q_main.push_back(tk(KB, 9'h070));
    q_main.push_back(tk(KM, 9'h070));
    req(1'b1, 1'b0, 4'd0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("stall_byte", {23'd0, byte_valid, byte_out}, {23'd0, 1'b1, 8'h70});
    end
    @(posedge clk);
    #1 ready = 1'b1;
    wait_idle(0);

    // Release of a key not held is ignored
    req(1'b0, 1'b1, 4'd9);
    @(negedge clk);
    check("ignored_rel_busy", {31'd0, busy}, 32'd0);
    check("ignored_rel_valid", {31'd0, byte_valid}, 32'd0);

    // Press during busy is dropped; in-flight sequence unaffected
    ready = 1'b0;
    q_main.push_back(tk(KD, 9'd0));
    q_main.push_back(tk(KB, 9'h072));
    q_main.push_back(tk(KM, 9'h072));
    req(1'b1, 1'b0, 4'd2);
    req(1'b1, 1'b0, 4'd4);
    repeat (2) @(posedge clk);
    #1 ready = 1'b1;
    wait_idle(0);
    check("held4_not_set", {31'd0, dut.held[4]}, 32'd0);

    // Press and release together on a held key: press wins (typematic repeat), no drop
    q_main.push_back(tk(KB, 9'h073));
    q_main.push_back(tk(KM, 9'h073));
    req(1'b1, 1'b1, 4'd5);
    wait_idle(0);
    check("held5_still", {31'd0, dut.held[5]}, 32'd1);

    // Reset between E0 and F0 of an extended break
    q_main.push_back(tk(KB, 9'h0E0));
    q_main.push_back(tk(KB, 9'h04A));
    q_main.push_back(tk(KM, 9'h14A));
    req(1'b1, 1'b0, 4'd11);
    wait_idle(0);
    ready = 1'b0;
    q_main.push_back(tk(KB, 9'h0E0));
    req(1'b0, 1'b1, 4'd11);
    ready = 1'b1;
    @(posedge clk);
    #1 ready = 1'b0; reset = 1'b1;
    @(negedge clk);
    check_reset_outputs("midreset");
    check("q_after_reset", q_main.size(), 32'd0);
    @(posedge clk);
    #1 reset = 1'b0; ready = 1'b1;
    q_main.push_back(tk(KB, 9'h069));
    q_main.push_back(tk(KM, 9'h069));
    req(1'b1, 1'b0, 4'd1);
    wait_idle(0);

    // GAP_CYCLES=2 instance: make key 3 (single byte, no gap), then break with 2 gap cycles
    q_gap.push_back(tk(KB, 9'h07A));
    q_gap.push_back(tk(KM, 9'h07A));
    g_req(1'b1, 1'b0, 4'd3);
    wait_idle(1);
    q_gap.push_back(tk(KB, 9'h0F0));
    q_gap.push_back(tk(KG, 9'd0));
    q_gap.push_back(tk(KG, 9'd0));
    q_gap.push_back(tk(KB, 9'h07A));
    q_gap.push_back(tk(KK, 9'h07A));
    g_req(1'b0, 1'b1, 4'd3);
    wait_idle(1);
    check("g_held3_clr", {31'd0, gdut.held[3]}, 32'd0);

    repeat (3) @(negedge clk);
    check("q_main_drained", q_main.size(), 32'd0);
    check("q_gap_drained", q_gap.size(), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
